// File: rtl/fasm_fifo_lvl_pkg.sv
// rtl/fasm_fifo_lvl_pkg.sv - shared sizing helpers and flag decode for fasm_fifo_lvl
package fasm_fifo_lvl_pkg;

    // Registered status flags, all derived from one occupancy value.
    typedef struct packed {
        logic rok;
        logic wok;
        logic aful;
        logic aemp;
    } fifo_flags_t;

    // Number of entries for a given address width.
    function automatic int fasm_depth(input int aw);
        return 1 << aw;
    endfunction

    // Level counter width: one extra bit so that "full" (2**AW) is representable.
    function automatic int fasm_lvl_w(input int aw);
        return aw + 1;
    endfunction

    // Decode the complete flag set from an occupancy value.
    function automatic fifo_flags_t fasm_flags(input int lvl, input int aw,
                                               input int afull, input int aempty);
        fifo_flags_t f;
        f.rok  = (lvl != 0);
        f.wok  = (lvl != fasm_depth(aw));
        f.aful = (lvl >= fasm_depth(aw) - afull);
        f.aemp = (lvl <= aempty);
        return f;
    endfunction

endpackage

// File: rtl/fasm_fifo_lvl_if.sv
// rtl/fasm_fifo_lvl_if.sv - producer/consumer bundle of the level-tracking FIFO
// master: the block using the FIFO (drives dat_i/wre_i/rde_i, observes status).
// slave : the FIFO itself.
interface fasm_fifo_lvl_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic [DW-1:0] dat_i;
    logic          wre_i;
    logic          rde_i;
    logic [DW-1:0] dat_o;
    logic          rok_o;
    logic          wok_o;
    logic [AW:0]   lvl_o;
    logic          aful_o;
    logic          aemp_o;
    logic          ovf_o;
    logic          udf_o;

    modport master (
        output dat_i, wre_i, rde_i,
        input  dat_o, rok_o, wok_o, lvl_o, aful_o, aemp_o, ovf_o, udf_o
    );

    modport slave (
        input  dat_i, wre_i, rde_i,
        output dat_o, rok_o, wok_o, lvl_o, aful_o, aemp_o, ovf_o, udf_o
    );
endinterface

// File: rtl/fasm_dpram.sv
// rtl/fasm_dpram.sv - 2**AW x DW storage, synchronous write port, asynchronous read port
// Ports: clk_i clock; wre/wadr/wdat write port; radr/rdat combinational read port.
// No reset: contents are only meaningful through the FIFO's pointers.
module fasm_dpram #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          wre,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdat,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdat
);
    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk_i) begin
        if (wre) begin
            mem[wadr] <= wdat;
        end
    end

    assign rdat = mem[radr];
endmodule

// File: rtl/fasm_fifo_lvl.sv
// rtl/fasm_fifo_lvl.sv - first-word-fall-through FIFO with level, almost flags and sticky errors
// Ports: clk_i clock; rst_i sync active-high reset; clr_i sync flush; ena_i clock enable;
//        bus (slave) carries dat_i/wre_i/rde_i in and dat_o/rok_o/wok_o/lvl_o/aful_o/
//        aemp_o/ovf_o/udf_o out.
module fasm_fifo_lvl
    import fasm_fifo_lvl_pkg::*;
#(
    parameter int AW     = 4,
    parameter int DW     = 32,
    parameter int AFULL  = 2,
    parameter int AEMPTY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            ena_i,
    fasm_fifo_lvl_if.slave  bus
);
    localparam int LW = fasm_lvl_w(AW);

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [LW-1:0] lvl;
    logic [LW-1:0] lvl_nxt;
    fifo_flags_t   flags;
    fifo_flags_t   flags_nxt;
    fifo_flags_t   flags_rst;
    logic          ovf;
    logic          udf;
    logic          wre_acc;
    logic          rde_acc;
    logic          flush;
    logic [DW-1:0] rdat;

    assign flush   = rst_i | clr_i;
    // Full/empty gating comes from the registered flags, so on a full FIFO a
    // simultaneous read+write pops only, and on an empty one it pushes only.
    assign wre_acc = ena_i & bus.wre_i & flags.wok;
    assign rde_acc = ena_i & bus.rde_i & flags.rok;

    always_comb begin
        lvl_nxt = lvl;
        case ({wre_acc, rde_acc})
            2'b10:   lvl_nxt = lvl + LW'(1);
            2'b01:   lvl_nxt = lvl - LW'(1);
            default: lvl_nxt = lvl;
        endcase
    end

    assign flags_nxt = fasm_flags(int'(lvl_nxt), AW, AFULL, AEMPTY);
    assign flags_rst = fasm_flags(0, AW, AFULL, AEMPTY);

    always_ff @(posedge clk_i) begin
        if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            lvl   <= '0;
            flags <= flags_rst;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (ena_i) begin
            if (wre_acc) wptr <= wptr + AW'(1);
            if (rde_acc) rptr <= rptr + AW'(1);
            lvl   <= lvl_nxt;
            flags <= flags_nxt;
            ovf   <= ovf | (bus.wre_i & ~flags.wok);
            udf   <= udf | (bus.rde_i & ~flags.rok);
        end
    end

    // A write coinciding with a flush is dropped rather than landing in storage.
    fasm_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i (clk_i),
        .wre   (wre_acc & ~flush),
        .wadr  (wptr),
        .wdat  (bus.dat_i),
        .radr  (rptr),
        .rdat  (rdat)
    );

    assign bus.dat_o  = rdat;
    assign bus.rok_o  = flags.rok;
    assign bus.wok_o  = flags.wok;
    assign bus.aful_o = flags.aful;
    assign bus.aemp_o = flags.aemp;
    assign bus.lvl_o  = lvl;
    assign bus.ovf_o  = ovf;
    assign bus.udf_o  = udf;
endmodule
